// File: rtl/router_fifo_ptr.sv
// 16-entry input buffer for one router port: in-order byte storage with binary
// pointers exported to the downstream binary_to_gray stage.
module router_fifo_ptr #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [AW-1:0]    wr_ptr,
  output logic [AW-1:0]    rd_ptr,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0]      wr5_q, wr5_d;
  logic [AW:0]      rd5_q, rd5_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  // Bit AW is the wrap bit: equal pointers mean empty, differing wrap bits
  // with equal addresses mean full.
  assign empty  = (wr5_q == rd5_q);
  assign full   = (wr5_q[AW] != rd5_q[AW]) && (wr5_q[AW-1:0] == rd5_q[AW-1:0]);
  assign count  = wr5_q - rd5_q;
  assign wr_ptr = wr5_q[AW-1:0];
  assign rd_ptr = rd5_q[AW-1:0];

  assign dout      = dout_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Acceptance looks only at start-of-cycle flags, so a read never frees a
  // slot for a same-cycle write and a write never feeds a same-cycle read.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr5_d       = wr5_q + {{AW{1'b0}}, wr_acc};
    rd5_d       = rd5_q + {{AW{1'b0}}, rd_acc};
    dout_d      = dout_q;
    if (rd_acc) begin
      dout_d = mem_q[rd5_q[AW-1:0]];
    end
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr5_q       <= '0;
      rd5_q       <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr5_q       <= wr5_d;
      rd5_q       <= rd5_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem_q[wr5_q[AW-1:0]] <= din;
    end
  end

endmodule
